// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU register-file slice.
//   REG_ZERO  - index of the hardwired-zero register
//   NUM_REGS  - architectural register count
//   REG_AW    - register address width
//   WORD_W    - data word width
//   popcount32() - population count of a register-sized bit vector
package cpu_pkg;

  localparam int REG_ZERO = 0;
  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;
  localparam int WORD_W   = 32;

  // Result is REG_AW+1 bits wide so that a count of NUM_REGS still fits.
  function automatic logic [REG_AW:0] popcount32(input logic [NUM_REGS-1:0] v);
    logic [REG_AW:0] n;
    n = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      n = n + {{REG_AW{1'b0}}, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/cpu_blocks.sv
// Generic building blocks used by the register file.
//   dff          - W-bit register with synchronous active-high reset and load enable
//                  ports: clk, reset, en, d[W], q[W]
//   decoder1to32 - 5-to-32 one-hot decoder, all zero when en=0
//                  ports: en, sel[5], y[32]
//   mux32to1by32 - 32-way word mux (W defaults to 32)
//                  ports: d[32][W], sel[5], y[W]
//   mux32to1by1  - 32-way bit mux
//                  ports: d[32], sel[5], y
//   mux2         - 2-way word mux, sel=1 picks b
//                  ports: a[W], b[W], sel, y[W]

module dff #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end
endmodule

module decoder1to32 (
  input  logic        en,
  input  logic [4:0]  sel,
  output logic [31:0] y
);
  always_comb begin
    y = '0;
    if (en) begin
      y[sel] = 1'b1;
    end
  end
endmodule

module mux32to1by32 #(
  parameter int W = 32
) (
  input  logic [31:0][W-1:0] d,
  input  logic [4:0]         sel,
  output logic [W-1:0]       y
);
  assign y = d[sel];
endmodule

module mux32to1by1 (
  input  logic [31:0] d,
  input  logic [4:0]  sel,
  output logic        y
);
  assign y = d[sel];
endmodule

module mux2 #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  output logic [W-1:0] y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard.
// Tracks which registers have an outstanding write, decides whether the
// issuing instruction must stall, counts reserved registers and flags
// write-backs that arrive for a register that was never reserved.
//
// Handshake: issue_req is the requester's valid; ~issue_stall is the ready.
// An issue transfers on a clock edge only when issue_req=1 and issue_stall=0
// in the same cycle; a stalled requester is expected to hold its fields
// and retry. issue_stall is forced low whenever issue_req is low.
//
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   rd_a_addr/rd_b_addr- source registers of the issuing instruction
//   issue_req          - issue request
//   issue_dest         - destination register of the issuing instruction
//   issue_stall        - combinational: issue refused this cycle
//   wb_en, wb_addr     - write-back valid and destination
//   wb_onehot          - one-hot decode of the write-back (zero when wb_en=0)
//   busy               - current busy vector (debug/observation)
//   busy_count         - registered popcount of busy
//   err_unreserved_wb  - sticky error flag
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int AW = REG_AW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [AW-1:0]        rd_a_addr,
  input  logic [AW-1:0]        rd_b_addr,
  input  logic                 issue_req,
  input  logic [AW-1:0]        issue_dest,
  output logic                 issue_stall,
  input  logic                 wb_en,
  input  logic [AW-1:0]        wb_addr,
  input  logic [NUM_REGS-1:0]  wb_onehot,
  output logic [NUM_REGS-1:0]  busy,
  output logic [AW:0]          busy_count,
  output logic                 err_unreserved_wb
);

  logic                busy_a;
  logic                busy_b;
  logic                busy_d;
  logic                busy_w;
  logic                out_a;
  logic                out_b;
  logic                out_d;
  logic                issue_accept;
  logic                err_set;
  logic [NUM_REGS-1:0] issue_onehot;
  logic [NUM_REGS-1:0] busy_next;

  mux32to1by1 u_busy_a (.d(busy), .sel(rd_a_addr),  .y(busy_a));
  mux32to1by1 u_busy_b (.d(busy), .sel(rd_b_addr),  .y(busy_b));
  mux32to1by1 u_busy_d (.d(busy), .sel(issue_dest), .y(busy_d));
  mux32to1by1 u_busy_w (.d(busy), .sel(wb_addr),    .y(busy_w));

  // A register being written back this cycle is no longer outstanding,
  // so an instruction waiting on it can issue in the same cycle (its
  // sources are forwarded from wb_data). busy[0] is never set, so
  // address 0 never contributes.
  assign out_a = busy_a & ~(wb_en & (wb_addr == rd_a_addr));
  assign out_b = busy_b & ~(wb_en & (wb_addr == rd_b_addr));
  assign out_d = busy_d & ~(wb_en & (wb_addr == issue_dest));

  assign issue_stall  = issue_req & (out_a | out_b | out_d);
  assign issue_accept = issue_req & ~issue_stall;

  decoder1to32 u_issue_dec (.en(issue_accept), .sel(issue_dest), .y(issue_onehot));

  // Clear first, then set: a same-edge write-back and re-reservation of
  // one register leaves it busy.
  always_comb begin
    busy_next = (busy & ~wb_onehot) | issue_onehot;
    busy_next[REG_ZERO] = 1'b0;
  end

  assign err_set = wb_en & (wb_addr != AW'(REG_ZERO)) & ~busy_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy              <= '0;
      busy_count        <= '0;
      err_unreserved_wb <= 1'b0;
    end else begin
      busy              <= busy_next;
      busy_count        <= popcount32(busy_next);
      err_unreserved_wb <= err_unreserved_wb | err_set;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// 32-entry register file with a busy scoreboard for the pipelined CPU.
// Two combinational read ports with same-cycle write-back forwarding, one
// write-back port, register 0 hardwired to zero. Registers 1..31 are dff
// instances loaded from a one-hot write-enable decode.
//
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   rd_a_addr, rd_a_data - read port A (issuing instruction's rs)
//   rd_b_addr, rd_b_data - read port B (issuing instruction's rt)
//   issue_req            - instruction requests issue
//   issue_dest           - destination register of the issuing instruction
//   issue_stall          - combinational: issue refused (RAW/WAW hazard)
//   wb_en, wb_addr, wb_data - write-back port
//   busy_count           - registered number of reserved registers
//   err_unreserved_wb    - sticky: write-back hit a non-busy register
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int W  = WORD_W,
  parameter int AW = REG_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] rd_a_addr,
  input  logic [AW-1:0] rd_b_addr,
  output logic [W-1:0]  rd_a_data,
  output logic [W-1:0]  rd_b_data,
  input  logic          issue_req,
  input  logic [AW-1:0] issue_dest,
  output logic          issue_stall,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [W-1:0]  wb_data,
  output logic [AW:0]   busy_count,
  output logic          err_unreserved_wb
);

  logic [NUM_REGS-1:0]        wb_onehot;
  logic [NUM_REGS-1:0][W-1:0] regs;
  logic [NUM_REGS-1:0]        busy;
  logic [W-1:0]               rd_a_reg;
  logic [W-1:0]               rd_b_reg;
  logic                       fwd_a;
  logic                       fwd_b;

  decoder1to32 u_wb_dec (.en(wb_en), .sel(wb_addr), .y(wb_onehot));

  // Register 0 has no storage; its decode bit only feeds the scoreboard,
  // where bit 0 is held clear anyway.
  assign regs[REG_ZERO] = '0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    dff #(.W(W)) u_reg (
      .clk  (clk),
      .reset(reset),
      .en   (wb_onehot[i]),
      .d    (wb_data),
      .q    (regs[i])
    );
  end

  mux32to1by32 #(.W(W)) u_rd_a_mux (.d(regs), .sel(rd_a_addr), .y(rd_a_reg));
  mux32to1by32 #(.W(W)) u_rd_b_mux (.d(regs), .sel(rd_b_addr), .y(rd_b_reg));

  // Forward the write-back value on an address match so a reader sees the
  // value being written this cycle; never forward onto register 0.
  assign fwd_a = wb_en & (wb_addr == rd_a_addr) & (rd_a_addr != AW'(REG_ZERO));
  assign fwd_b = wb_en & (wb_addr == rd_b_addr) & (rd_b_addr != AW'(REG_ZERO));

  mux2 #(.W(W)) u_rd_a_fwd (.a(rd_a_reg), .b(wb_data), .sel(fwd_a), .y(rd_a_data));
  mux2 #(.W(W)) u_rd_b_fwd (.a(rd_b_reg), .b(wb_data), .sel(fwd_b), .y(rd_b_data));

  reg_scoreboard #(.AW(AW)) u_sb (
    .clk              (clk),
    .reset            (reset),
    .rd_a_addr        (rd_a_addr),
    .rd_b_addr        (rd_b_addr),
    .issue_req        (issue_req),
    .issue_dest       (issue_dest),
    .issue_stall      (issue_stall),
    .wb_en            (wb_en),
    .wb_addr          (wb_addr),
    .wb_onehot        (wb_onehot),
    .busy             (busy),
    .busy_count       (busy_count),
    .err_unreserved_wb(err_unreserved_wb)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

  localparam int W  = 32;
  localparam int AW = 5;

  // ---------------- clock / reset / DUT ----------------
  logic          clk;
  logic          reset;
  logic [AW-1:0] rd_a_addr;
  logic [AW-1:0] rd_b_addr;
  logic [W-1:0]  rd_a_data;
  logic [W-1:0]  rd_b_data;
  logic          issue_req;
  logic [AW-1:0] issue_dest;
  logic          issue_stall;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [W-1:0]  wb_data;
  logic [AW:0]   busy_count;
  logic          err_unreserved_wb;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  regfile_scoreboard #(.W(W), .AW(AW)) dut (
    .clk              (clk),
    .reset            (reset),
    .rd_a_addr        (rd_a_addr),
    .rd_b_addr        (rd_b_addr),
    .rd_a_data        (rd_a_data),
    .rd_b_data        (rd_b_data),
    .issue_req        (issue_req),
    .issue_dest       (issue_dest),
    .issue_stall      (issue_stall),
    .wb_en            (wb_en),
    .wb_addr          (wb_addr),
    .wb_data          (wb_data),
    .busy_count       (busy_count),
    .err_unreserved_wb(err_unreserved_wb)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           total;
  int           bad;

  logic [W-1:0] m_regs [32];
  logic         m_busy [32];
  logic         m_err;

  logic [W-1:0] obs_rd_a;
  logic [W-1:0] obs_rd_b;
  logic         obs_stall;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_read(input logic [4:0] ra, input logic we,
                                              input logic [4:0] wa, input logic [W-1:0] wd);
    if (ra == 5'd0) return '0;
    if (we && wa == ra) return wd;
    return m_regs[ra];
  endfunction

  function automatic logic model_out(input logic [4:0] r, input logic we, input logic [4:0] wa);
    return (r != 5'd0) && m_busy[r] && !(we && wa == r);
  endfunction

  function automatic logic [W-1:0] model_count();
    logic [W-1:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + (m_busy[i] ? 1 : 0);
    return n;
  endfunction

  // ---------------- driver ----------------
  // One clock cycle: drive inputs, check combinational outputs mid-cycle,
  // advance the model on the edge, check registered outputs after it.
  task automatic cycle(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [W-1:0] wd, input logic ir, input logic [4:0] id,
                       input logic [4:0] ra, input logic [4:0] rb);
    logic st;
    reset = rst; wb_en = we; wb_addr = wa; wb_data = wd;
    issue_req = ir; issue_dest = id; rd_a_addr = ra; rd_b_addr = rb;
    st = ir && (model_out(ra, we, wa) || model_out(rb, we, wa) || model_out(id, we, wa));
    exp_q.push_back(model_read(ra, we, wa, wd));
    exp_q.push_back(model_read(rb, we, wa, wd));
    exp_q.push_back({31'b0, st});
    @(negedge clk);
    obs_rd_a = rd_a_data; obs_rd_b = rd_b_data; obs_stall = issue_stall;
    check("rd_a_data", rd_a_data, exp_q.pop_front());
    check("rd_b_data", rd_b_data, exp_q.pop_front());
    check("issue_stall", {31'b0, issue_stall}, exp_q.pop_front());
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
      m_err = 1'b0;
    end else begin
      if (we && wa != 5'd0) begin
        if (!m_busy[wa]) m_err = 1'b1;
        m_regs[wa] = wd;
        m_busy[wa] = 1'b0;
      end
      if (ir && !st && id != 5'd0) m_busy[id] = 1'b1;
    end
    exp_q.push_back(model_count());
    exp_q.push_back({31'b0, m_err});
    @(posedge clk);
    #1;
    check("busy_count", {26'b0, busy_count}, exp_q.pop_front());
    check("err_unreserved_wb", {31'b0, err_unreserved_wb}, exp_q.pop_front());
  endtask

  task automatic idle(input logic [4:0] ra);
    cycle(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, ra, 5'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_err = 1'b0;
    reset = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    issue_req = 1'b0; issue_dest = '0; rd_a_addr = '0; rd_b_addr = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset wins over same-cycle write-back and issue to reg 3.
    cycle(1'b1, 1'b1, 5'd3, 32'hFFFF_FFFF, 1'b1, 5'd3, 5'd3, 5'd0);
    idle(5'd3);
    check("rst_rd3", obs_rd_a, 32'h0);
    check("rst_cnt", {26'b0, busy_count}, 32'd0);
    check("rst_err", {31'b0, err_unreserved_wb}, 32'd0);

    // Register 0 discards writes and never flags.
    cycle(1'b0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd0, 5'd0);
    idle(5'd0);
    check("r0_read", obs_rd_a, 32'h0);
    check("r0_err", {31'b0, err_unreserved_wb}, 32'd0);

    // Unreserved write to reg 5: data lands, error sets.
    cycle(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd5, 5'd0);
    idle(5'd5);
    check("r5_read", obs_rd_a, 32'hDEAD_BEEF);
    check("r5_err", {31'b0, err_unreserved_wb}, 32'd1);

    // RAW stall and release with forwarding.
    cycle(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd7, 5'd1, 5'd2);
    check("raw_cnt1", {26'b0, busy_count}, 32'd1);
    cycle(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd7, 5'd7, 5'd2);
    check("raw_stall", {31'b0, obs_stall}, 32'd1);
    cycle(1'b0, 1'b1, 5'd7, 32'hA5A5_0000, 1'b1, 5'd7, 5'd7, 5'd2);
    check("raw_release", {31'b0, obs_stall}, 32'd0);
    check("raw_fwd", obs_rd_a, 32'hA5A5_0000);
    check("raw_cnt2", {26'b0, busy_count}, 32'd1);
    cycle(1'b0, 1'b1, 5'd7, 32'h0000_0007, 1'b0, 5'd0, 5'd0, 5'd0);

    // WAW on reg 9.
    cycle(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd9, 5'd0, 5'd0);
    cycle(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd9, 5'd1, 5'd2);
    check("waw_stall", {31'b0, obs_stall}, 32'd1);
    idle(5'd0);
    check("waw_cnt", {26'b0, busy_count}, 32'd1);
    cycle(1'b0, 1'b1, 5'd9, 32'h9999_0009, 1'b0, 5'd0, 5'd9, 5'd0);
    check("waw_clear", {26'b0, busy_count}, 32'd0);

    // Same-edge write-back and re-reservation of reg 12.
    cycle(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd12, 5'd0, 5'd0);
    cycle(1'b0, 1'b1, 5'd12, 32'h0C0C_1212, 1'b1, 5'd12, 5'd0, 5'd12);
    check("sim_stall", {31'b0, obs_stall}, 32'd0);
    check("sim_cnt", {26'b0, busy_count}, 32'd1);
    idle(5'd12);
    check("sim_data", obs_rd_a, 32'h0C0C_1212);
    cycle(1'b0, 1'b1, 5'd12, 32'h1, 1'b0, 5'd0, 5'd0, 5'd0);

    // Fill and drain from a clean reset.
    cycle(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0, 5'd0);
    for (int i = 1; i < 32; i++) begin
      cycle(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'(i), 5'd0, 5'd0);
    end
    check("fill_cnt", {26'b0, busy_count}, 32'd31);
    for (int i = 31; i >= 1; i--) begin
      cycle(1'b0, 1'b1, 5'(i), 32'(i * 32'h0101_0101), 1'b0, 5'd0, 5'(i), 5'd0);
      check("drain_cnt", {26'b0, busy_count}, 32'(i - 1));
    end
    check("drain_err", {31'b0, err_unreserved_wb}, 32'd0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 49) == 0,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
